// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: funct3 opcodes, FSM state encodings and operand-sign helpers.
package muldiv_unit_pkg;
    typedef enum logic [2:0] {
        F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU, F3_DIV, F3_DIVU, F3_REM, F3_REMU
    } f3_e;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_e;
    function automatic int MD_CNT_W(input int xlen);
        return $clog2(xlen) + 1;
    endfunction
    function automatic logic rs1_signed(input logic [2:0] op);
        return !(op == F3_MULHU || op == F3_DIVU || op == F3_REMU);
    endfunction
    function automatic logic rs2_signed(input logic [2:0] op);
        return op == F3_MUL || op == F3_MULH || op == F3_DIV || op == F3_REM;
    endfunction
endpackage

// File: rtl/muldiv_unit_sign_fix.sv
// muldiv_sign_fix: operand magnitudes at accept and conditional two's-complement of the raw result.
module muldiv_sign_fix
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              neg1,
    output logic              neg2,
    input  logic [2*XLEN-1:0] raw,
    input  logic              neg,
    output logic [2*XLEN-1:0] fixed
);
    always_comb begin
        neg1  = rs1_signed(op) & rs1[XLEN-1];
        neg2  = rs2_signed(op) & rs2[XLEN-1];
        mag1  = neg1 ? '0 - rs1 : rs1;
        mag2  = neg2 ? '0 - rs2 : rs2;
        fixed = neg ? '0 - raw : raw;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide for RV32M/RV64M.
// Define MULDIV_FAST_MUL_EN to compute multiplies with a single-cycle multiplier in FIX.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = MD_CNT_W(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      F3,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    md_state_e state, next;
    f3_e op_q;
    logic [XLEN-1:0] a_q, b_q, spec_q, mag1, mag2, spec_val, final_res;
    logic [2*XLEN-1:0] acc, acc_nxt, prod, raw, fixed;
    logic [XLEN:0] sum, diff;
    logic [CNT_W-1:0] cnt;
    logic neg1, neg2, s1_q, s2_q, spec_flag, accept, div0, ovf, special, fast, neg;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op    (F3),
        .rs1   (rs1_i),
        .rs2   (rs2_i),
        .mag1  (mag1),
        .mag2  (mag2),
        .neg1  (neg1),
        .neg2  (neg2),
        .raw   (raw),
        .neg   (neg),
        .fixed (fixed)
    );

`ifdef MULDIV_FAST_MUL_EN
    assign fast = ~F3[2];
    assign prod = (2*XLEN)'(a_q) * (2*XLEN)'(b_q);
`else
    assign fast = 1'b0;
    assign prod = acc;
`endif

    always_comb begin
        accept   = valid_i & ~flush_i & (state == MD_IDLE);
        div0     = F3[2] & (rs2_i == '0);
        ovf      = (F3 == F3_DIV || F3 == F3_REM) & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
        special  = div0 | ovf;
        spec_val = div0 ? (F3[1] ? rs1_i : '1) : (F3[1] ? '0 : rs1_i);
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_q} : '0);
        diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        // Divide: a negative trial difference restores, i.e. just shifts in a 0 quotient bit.
        acc_nxt  = op_q[2] ? (diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                           : {sum, acc[XLEN-1:1]};
        raw      = op_q[2] ? {{XLEN{1'b0}}, op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0]} : prod;
        neg      = (op_q[2] & op_q[1]) ? s1_q : s1_q ^ s2_q;
        final_res = spec_flag ? spec_q
                  : (op_q == F3_MUL || op_q[2]) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= next;
    end

    always_comb begin
        next = flush_i ? MD_IDLE
             : state == MD_IDLE ? (valid_i ? ((special | fast) ? MD_FIX : MD_CALC) : MD_IDLE)
             : state == MD_CALC ? (cnt == CNT_W'(1) ? MD_FIX : MD_CALC)
             : state == MD_FIX  ? MD_DONE : MD_IDLE;
    end

    always_comb begin
        ready_o = state == MD_IDLE;
        busy_o  = ~ready_o;
        done_o  = state == MD_DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= F3_MUL;
            a_q       <= '0;
            b_q       <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            spec_flag <= 1'b0;
            spec_q    <= '0;
            cnt       <= '0;
            acc       <= '0;
            result_o  <= '0;
        end else if (accept) begin
            op_q      <= f3_e'(F3);
            a_q       <= mag1;
            b_q       <= mag2;
            s1_q      <= neg1;
            s2_q      <= neg2;
            spec_flag <= special;
            spec_q    <= spec_val;
            cnt       <= CNT_W'(XLEN);
            acc       <= {{XLEN{1'b0}}, F3[2] ? mag1 : mag2};
        end else if (state == MD_CALC) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_nxt;
        end else if (state == MD_FIX && !flush_i) begin
            result_o <= final_res;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed table, control sequences and random ops against an arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
`ifdef MULDIV_FAST_MUL_EN
    localparam int ML = 2;
`else
    localparam int ML = 34;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, flush_i = 1'b0;
    logic [2:0] F3 = 3'd0;
    logic [31:0] rs1_i = '0, rs2_i = '0, result_o;
    logic ready_o, busy_o, done_o;
    int total = 0, bad = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .F3       (F3),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sp;
        logic [63:0] up;
        int q;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MUL:    begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[31:0]; end
            MULH:   begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
            MULHSU: begin sp = longint'($signed(a)) * longint'({32'h0, b}); return sp[63:32]; end
            MULHU:  begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
            DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return ML;
        if (b == 0) return 2;
        if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        for (int i = 0; i < 50 && !ready_o; i++) begin @(posedge clk); #1; end
        valid_i = 1'b1; F3 = op; rs1_i = a; rs2_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 100) begin @(posedge clk); #1; lat++; end
        res = result_o;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            4: return 32'hFFFF_FFFF - $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t tbl[13];
        logic [31:0] r, a, b;
        logic [2:0] op;
        int l, ndone;
        tbl[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, ML};
        tbl[1]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        tbl[2]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        tbl[3]  = '{DIVU,   32'd100,        32'd0,         32'hFFFF_FFFF, 2};
        tbl[4]  = '{REMU,   32'd100,        32'd0,         32'h0000_0064, 2};
        tbl[5]  = '{DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        tbl[6]  = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        tbl[7]  = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 2};
        tbl[8]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
        tbl[9]  = '{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, ML};
        tbl[10] = '{MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
        tbl[11] = '{REM,    32'd5,          32'd0,         32'd5,         2};
        tbl[12] = '{DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_result", result_o, 0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, l);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].exp);
            chk($sformatf("tbl%0d_latency", i), l, tbl[i].lat);
        end

        run_op(REMU, 32'h1234, 32'h0, r, l);
        chk("pre_flush_result", r, 32'h1234);
        @(posedge clk); #1;
        chk("done_one_cycle", done_o, 0);
        chk("ready_after_done", ready_o, 1);
        valid_i = 1'b1; F3 = DIV; rs1_i = 32'd1000; rs2_i = 32'd7;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_ready", ready_o, 1);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done_o) ndone++; end
        chk("flush_no_done", ndone, 0);
        chk("flush_result_held", result_o, 32'h1234);

        valid_i = 1'b1; F3 = MUL; rs1_i = 32'd3; rs2_i = 32'd5;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done_o) begin ndone++; valid_i = 1'b0; end
        end
        valid_i = 1'b0;
        chk("held_valid_one_done", ndone, 1);
        chk("held_valid_result", result_o, 32'd15);

        valid_i = 1'b1; F3 = DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        chk("midrst_result", result_o, 0);
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (done_o) ndone++; end
        chk("midrst_discarded", ndone, 0);

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            run_op(op, a, b, r, l);
            chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, op, a, b), r, ref_model(op, a, b));
            chk($sformatf("rnd%0d_op%0d_latency", i, op), l, ref_lat(op, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
